// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small byte FIFO in front of the shift FSM.
// Line idles high; bytes go out LSB first; host is stalled via o_tx_ready when the FIFO is full.
module uart_tx #(
  parameter int CLOCK_FREQUENCY = 50_000_000,
  parameter int BAUD_RATE       = 115200,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_tx_valid,
  input  logic [7:0]                    i_tx_byte,
  output logic                          o_tx_ready,
  output logic                          o_tx_serial,
  output logic                          o_tx_busy,
  output logic                          o_tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

  localparam int CLKS_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [BW-1:0] BAUD_LOAD  = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          serial_q, serial_d;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    fifo_mem_q [FIFO_DEPTH];
  logic          push, pop, fifo_empty, baud_end;

  assign fifo_empty = (count_q == '0);
  assign o_tx_ready = (count_q != FULL_COUNT);
  assign push       = i_tx_valid & o_tx_ready;
  assign baud_end   = (baud_q == '0);

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    serial_d  = serial_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          shift_d  = fifo_mem_q[rd_ptr_q];
          baud_d   = BAUD_LOAD;
          serial_d = 1'b0;
          state_d  = START;
        end
      end
      START: begin
        if (baud_end) begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
          baud_d    = BAUD_LOAD;
          serial_d  = shift_q[0];
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d = BAUD_LOAD;
          if (bit_idx_q == 3'd7) begin
            state_d  = STOP;
            serial_d = 1'b1;
          end else begin
            // shift_q[0] is the bit on the line; bit 1 is the next one out
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = shift_q >> 1;
            serial_d  = shift_q[1];
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      STOP: begin
        if (baud_end) begin
          if (!fifo_empty) begin
            pop      = 1'b1;
            shift_d  = fifo_mem_q[rd_ptr_q];
            baud_d   = BAUD_LOAD;
            serial_d = 1'b0;
            state_d  = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      serial_q  <= 1'b1;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      serial_q  <= serial_d;
      count_q   <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // Storage needs no reset: contents are only read behind a non-zero count.
  always_ff @(posedge i_clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= i_tx_byte;
  end

  assign o_tx_serial  = serial_q;
  assign o_tx_busy    = (state_q != IDLE);
  assign o_tx_done    = (state_q == STOP) && baud_end;
  assign o_fifo_count = count_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: frame-level reference model checked every cycle, a line receiver
// scoreboard, a table of single-byte frames and hand-written FIFO/reset corner sequences.
module tb_uart_tx;
  localparam int CPB   = 10;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic       ready, serial, busy, done;
  logic [2:0] count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx #(.CLOCK_FREQUENCY(1_000_000), .BAUD_RATE(100_000), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst(rst), .i_tx_valid(valid), .i_tx_byte(tx_byte),
    .o_tx_ready(ready), .o_tx_serial(serial), .o_tx_busy(busy), .o_tx_done(done),
    .o_fifo_count(count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of waiting bytes and a position inside the current 100-cycle frame.
  logic [7:0] mq[$];
  logic [7:0] exp_tx[$];
  logic [7:0] cur = 8'h00;
  int         pos = -1;
  bit         m_rdy, m_pop;

  always @(posedge clk) begin
    m_rdy = (mq.size() != DEPTH);
    if (rst) begin
      mq.delete();
      exp_tx.delete();
      pos = -1;
    end else begin
      m_pop = (pos < 0 || pos == FRAME - 1) && mq.size() > 0;
      if (m_pop) begin
        cur = mq.pop_front();
        exp_tx.push_back(cur);
        pos = 0;
      end else if (pos == FRAME - 1) pos = -1;
      else if (pos >= 0) pos++;
      if (valid && m_rdy) mq.push_back(tx_byte);
    end
  end

  function automatic logic exp_line();
    int b;
    if (pos < 0) return 1'b1;
    b = pos / CPB;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return cur[b-1];
  endfunction

  logic [6:0] act_v, exp_v;
  always @(negedge clk) begin
    act_v = {serial, busy, done, ready, count};
    exp_v = {exp_line(), pos >= 0, pos == FRAME - 1, mq.size() != DEPTH, 3'(mq.size())};
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL cycle_outputs {ser,busy,done,rdy,cnt}: got %b expected %b (t=%0t)", act_v, exp_v, $time);
    end
  end

  // Line receiver: samples mid-bit and scores each byte against what the model sent.
  int         rx_pos = -1;
  int         rx_bit;
  logic [7:0] rx_sh = 8'h00;
  logic [7:0] rx_log[$];
  logic [7:0] rx_exp;
  always @(negedge clk) begin
    if (rst) rx_pos = -1;
    else if (rx_pos < 0) begin
      if (serial === 1'b0) rx_pos = 0;
    end else begin
      rx_pos++;
      if (rx_pos % CPB == CPB / 2) begin
        rx_bit = rx_pos / CPB;
        if (rx_bit >= 1 && rx_bit <= 8) rx_sh[rx_bit-1] = serial;
        else if (rx_bit == 9) begin
          check("rx_stop_bit", serial, 1'b1);
          rx_log.push_back(rx_sh);
          rx_exp = (exp_tx.size() > 0) ? exp_tx.pop_front() : ~rx_sh;
          check("rx_byte", rx_sh, rx_exp);
          rx_pos = -1;
        end
      end
    end
  end

  int cyc = 0;
  int done_cyc[$];
  int busy_run = 0, last_run = 0, peak = 0;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (done === 1'b1) done_cyc.push_back(cyc);
    if (busy === 1'b1) busy_run++;
    else begin
      if (busy_run > 0) last_run = busy_run;
      busy_run = 0;
    end
    if (int'(count) > peak) peak = int'(count);
  end

  task automatic push(input logic [7:0] b);
    int n = 0;
    valid = 1'b1;
    tx_byte = b;
    while (ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (ready !== 1'b1) check("push_timeout", 0, 1);
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy !== 1'b0 || count !== 3'd0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0 || count !== 3'd0) check("idle_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic wait_fall(input int budget);
    int n = 0;
    while (serial !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (serial !== 1'b0) check("start_timeout", 0, 1);
  endtask

  typedef struct {
    logic [7:0] b;
    logic [9:0] frame;  // {stop, data[7:0], start}, bit i is the i-th bit time on the line
  } vec_t;

  vec_t       vecs[5];
  logic [7:0] full_exp[6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{8'hA5, 10'b1_10100101_0};
    vecs[1] = '{8'h00, 10'b1_00000000_0};
    vecs[2] = '{8'h7E, 10'b1_01111110_0};
    vecs[3] = '{8'hFF, 10'b1_11111111_0};
    vecs[4] = '{8'h81, 10'b1_10000001_0};
    full_exp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h77};

    repeat (3) @(negedge clk);
    check("reset_serial", serial, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_ready", ready, 1'b1);
    check("reset_count", count, 3'd0);
    rst = 1'b0;

    // Single-byte frames sampled at mid-bit.
    for (int v = 0; v < 5; v++) begin
      done_cyc.delete();
      push(vecs[v].b);
      wait_fall(5);
      repeat (CPB / 2) @(negedge clk);
      for (int i = 0; i < 10; i++) begin
        check($sformatf("frame_%02h_bit%0d", vecs[v].b, i), serial, vecs[v].frame[i]);
        if (i < 9) repeat (CPB) @(negedge clk);
      end
      wait_idle(200);
      check("single_done_pulses", done_cyc.size(), 1);
      check("single_busy_len", last_run, FRAME);
    end

    // Back-to-back frames with no idle gap.
    done_cyc.delete();
    peak = 0;
    push(8'h00);
    push(8'hFF);
    push(8'h55);
    wait_idle(1000);
    check("b2b_peak_count", peak, 2);
    check("b2b_busy_len", last_run, 3 * FRAME);
    check("b2b_done_pulses", done_cyc.size(), 3);
    if (done_cyc.size() == 3) begin
      check("b2b_done_gap1", done_cyc[1] - done_cyc[0], FRAME);
      check("b2b_done_gap2", done_cyc[2] - done_cyc[1], FRAME);
    end

    // Full FIFO, ignored push, then a push held across the pop edge.
    rx_log.delete();
    push(8'h11);
    push(8'h22);
    push(8'h33);
    push(8'h44);
    push(8'h55);
    check("full_ready", ready, 1'b0);
    check("full_count", count, 3'd4);
    valid = 1'b1;
    tx_byte = 8'h66;
    repeat (20) @(negedge clk);
    check("full_ignore_count", count, 3'd4);
    tx_byte = 8'h77;
    begin
      int n = 0;
      while (count === 3'd4 && n < 300) begin
        @(negedge clk);
        n++;
      end
    end
    check("popedge_count", count, 3'd3);
    check("popedge_ready", ready, 1'b1);
    @(negedge clk);
    valid = 1'b0;
    check("after_pop_count", count, 3'd4);
    wait_idle(1500);
    check("full_rx_len", rx_log.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < rx_log.size()) check($sformatf("full_rx_%0d", i), rx_log[i], full_exp[i]);

    // Reset during data bit 4 with another byte queued.
    rx_log.delete();
    done_cyc.delete();
    push(8'h3C);
    push(8'h5A);
    wait_fall(5);
    repeat (5 * CPB + 3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_serial", serial, 1'b1);
    check("midrst_count", count, 3'd0);
    check("midrst_busy", busy, 1'b0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_no_done", done_cyc.size(), 0);
    check("midrst_no_rx", rx_log.size(), 0);
    push(8'h81);
    wait_idle(300);
    check("midrst_rx_len", rx_log.size(), 1);
    if (rx_log.size() == 1) check("midrst_rx_byte", rx_log[0], 8'h81);

    // Randomized traffic scored by the model and the receiver.
    rx_log.delete();
    for (int c = 0; c < 4000; c++) begin
      valid = ($urandom_range(0, 3) == 0);
      tx_byte = 8'($urandom);
      @(negedge clk);
    end
    valid = 1'b0;
    wait_idle(1000);
    check("rand_scoreboard_drained", exp_tx.size(), 0);
    check("rand_rx_nonzero", rx_log.size() > 20, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- 8N1 UART transmitter: 8 data bits, LSB first, one start bit, one stop bit, no parity.
- A small FIFO buffers bytes so the host can queue several bytes without waiting for each frame.
- Sits between the co-processor result path and the FPGA TX pin; it is the counterpart of the UART receiver on the same link.
- Line idles high.

Parameters:
- CLOCK_FREQUENCY, 50_000_000: i_clk frequency in Hz.
- BAUD_RATE, 115200: line bit rate. CLKS_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE, integer division (434 at defaults); must be >= 2.
- FIFO_DEPTH, 4: byte FIFO entries; must be a power of two, >= 2.

Ports:
- i_clk  in  1  system clock; all logic on posedge.
- i_rst  in  1  synchronous, active-high reset.
- i_tx_valid  in  1  host presents a byte.
- i_tx_byte  in  8  byte to send; sampled when i_tx_valid & o_tx_ready.
- o_tx_ready  out  1  FIFO can accept a byte (not full).
- o_tx_serial  out  1  serial line, registered, idle high.
- o_tx_busy  out  1  frame in progress (FSM not in IDLE).
- o_tx_done  out  1  one-cycle pulse on the last cycle of each stop bit.
- o_fifo_count  out  $clog2(FIFO_DEPTH)+1  bytes queued (not counting the byte being sent).

Behaviour:
- Reset (i_rst high at a posedge):
  - outputs: o_tx_serial=1, o_tx_busy=0, o_tx_done=0, o_tx_ready=1, o_fifo_count=0;
  - internals: FIFO pointers cleared, baud counter=0, bit index=0, FSM=IDLE.
  - Reset has priority over every other event.
- Reset mid-frame: at the next edge the line returns high, the frame is abandoned, queued bytes are discarded, no o_tx_done pulse is produced.
- Push handshake:
  - Byte accepted on an edge where i_tx_valid & o_tx_ready; o_fifo_count increments at that edge.
  - o_tx_ready = (o_fifo_count != FIFO_DEPTH), combinational from registered count.
  - When full, a push is rejected even if a pop occurs on the same edge.
  - i_tx_valid while not ready is ignored; the host holds the byte.
- Simultaneous push and pop when not full: count unchanged, both take effect.
- FSM states: IDLE, START, DATA, STOP.
- IDLE -> START:
  - Taken when o_fifo_count != 0 at the edge.
  - The head byte is popped into a shift register, the baud counter is loaded, and o_tx_serial=0 from that edge.
- START:
  - Line held 0 for CLKS_PER_BIT cycles.
  - Then -> DATA with bit index 0; line = byte[0].
- DATA:
  - Each bit is held CLKS_PER_BIT cycles; bits go out byte[0] through byte[7].
  - After bit 7 completes -> STOP, line=1.
- STOP:
  - Line held 1 for CLKS_PER_BIT cycles; o_tx_done is high for exactly the last of those cycles.
  - At the end of STOP: if FIFO non-empty, pop and go straight to START (no extra idle cycles); else -> IDLE.
- Frame length: exactly 10*CLKS_PER_BIT cycles from the start-bit falling edge to the end of the stop bit.
- Latency: push accepted at edge k into an empty FIFO with FSM IDLE -> the count is 1 after edge k, the pop happens at edge k+1, and o_tx_serial falls after edge k+1.
- o_tx_busy: 1 from the edge entering START through the final STOP cycle; 0 in IDLE. It stays 1 across back-to-back frames.
- Baud counter:
  - Width $clog2(CLKS_PER_BIT).
  - Counts CLKS_PER_BIT-1 down to 0; a state/bit advance happens when it reaches 0.
  - It is reloaded on every advance and never wraps unloaded.
- FIFO:
  - Read and write pointers are $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
  - Full/empty are derived from o_fifo_count.
  - No pop when empty; no overwrite when full.
- o_tx_serial is driven from a flop; it must not glitch between bits.

Test Plan (CLOCK_FREQUENCY=1_000_000, BAUD_RATE=100_000 -> CLKS_PER_BIT=10, FIFO_DEPTH=4):
- Single byte: after reset, push 0xA5 -> line low 10 cycles, then 1,0,1,0,0,1,0,1 for 10 cycles each, then high 10 cycles. o_tx_done pulses once on cycle 100 of the frame; o_tx_busy then drops.
- Back-to-back: push 0x00, 0xFF, 0x55 on consecutive cycles -> o_fifo_count peaks at 2. Three frames of exactly 100 cycles each, no idle gap; three o_tx_done pulses 100 cycles apart; busy continuously 1 for 300 cycles.
- Full FIFO: push 0x11 (enters transmission), then 0x22, 0x33, 0x44, 0x55 so the FIFO is full with 4 queued. o_tx_ready=0 and o_fifo_count=4; a further push of 0x66 is ignored. Transmitted sequence must be 0x11, 0x22, 0x33, 0x44, 0x55.
- Push at pop: with FIFO full, hold i_tx_valid with 0x77 across the end of the current frame -> 0x77 is accepted only on the edge after the pop (count 4 -> 3 -> 4); no byte is lost or duplicated.
- Reset mid-frame: push 0x3C, assert i_rst during data bit 4 with a second byte queued -> line high on the next edge, o_fifo_count=0, no o_tx_done. A subsequent push of 0x81 transmits a clean frame.
- Loopback: connect o_tx_serial to the team's UART receiver, send 0x00, 0x7E, 0xFF, 0xA5 -> the receiver reports the same four bytes in order.
